pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the pipelined core's IF stage, superseding the fixed 32-bit PC register. It holds the fetch address, advances it sequentially, and takes redirects from trap, branch/jump and return sources. Redirects that arrive during a stall are latched rather than lost. An optional return-address stack (RAS) supplies `ret` targets.

## Interface
- WIDTH, 32, PC width in bits.
- RESET_VEC, 0, PC value after reset.
- TRAP_VEC, 'h80, PC target on trap.
- INC, 4, sequential increment.
- RAS_DEPTH, 4, RAS entries (power of two, ≥2; used only with PC_RAS_EN).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- pc_write_i  in  1  1 = PC may update this cycle; 0 = stall (hold).
- trap_i  in  1  redirect to TRAP_VEC.
- redirect_valid_i  in  1  branch/jump/ret redirect request.
- redirect_pc_i  in  WIDTH  redirect target.
- call_i  in  1  qualifies redirect as a call: push return address.
- ret_i  in  1  qualifies redirect as a return: pop RAS for target.
- pc_o  out  WIDTH  current fetch PC.
- pending_o  out  1  a latched redirect awaits application.
- ras_empty_o  out  1  RAS holds no entries.

## Operation
- Reset (asynchronous, any time): pc_o=RESET_VEC, pending_o=0, RAS count=0, ras_empty_o=1, pending kind cleared. A reset mid-stall discards any pending redirect.
- Request selection each cycle, highest priority first:
  - trap_i
  - redirect_valid_i
  - pending entry
  - sequential pc_o+INC
- Arithmetic is modulo 2^WIDTH: pc_o+INC wraps to 0. redirect_pc_i is used verbatim, with no alignment masking.
- pc_write_i=1: pc_o ← selected target. A pending entry is cleared when it is consumed, and also when it is overridden by a live trap or redirect.
- pc_write_i=0: pc_o holds.
  - A live trap is latched as pending (kind=trap) and replaces any entry.
  - A live redirect is latched (kind=redirect, target, call/ret flags) only if no trap is pending. It overwrites an older pending redirect (the newest wins).
- call_i/ret_i are ignored unless redirect_valid_i=1. RAS operations occur only when the redirect is actually applied to pc_o, whether direct or from pending; a trap never touches the RAS.
- Call:
  - Push the address of the call site + INC, i.e. pc_o+INC at the cycle the call is applied.
  - Target is redirect_pc_i.
  - RAS full: push overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
- Ret:
  - Target is the RAS top, which is then popped.
  - RAS empty: target falls back to redirect_pc_i and there is no pop.
- call_i and ret_i together: pop for target, then push the return address (top replaced, count unchanged). If the RAS is empty: fallback target and push, count=1.
- pending_o is 1 while a pending entry exists.

## Timing
- Single-cycle: inputs are sampled on a rising clk_i and pc_o updates on that edge.
- Latency from request to new pc_o: 1 cycle unstalled. For a request that arrives during a stall, the new pc_o appears on the first edge with pc_write_i=1.
- pending_o rises the edge after a stalled request and falls on the consuming edge.
- ras_empty_o updates on the same edge as the push/pop.
- No combinational path from any input to pc_o; all outputs are registered.

## Configuration
- PC_RAS_EN defined:
  - RAS of RAS_DEPTH×WIDTH built.
  - call_i/ret_i behave as specified.
- PC_RAS_EN undefined:
  - No RAS storage.
  - call_i/ret_i are ignored; any redirect targets redirect_pc_i.
  - ras_empty_o is tied to 1.

## Test plan
- Reset then free-run (WIDTH=32, INC=4): pc_o=0 during reset, then 4, 8, 12 on successive edges. Asserting rst_i between edges forces pc_o=0 immediately, without waiting for a clock.
- Wrap: WIDTH=8, force pc_o=0xFC via redirect -> next edge pc_o=0x00.
- Stalled redirect:
  - With pc_write_i=0, pulse redirect_valid_i with redirect_pc_i=0x100 -> pc_o holds and pending_o=1.
  - A second stalled redirect to 0x200 -> still pending.
  - Release the stall -> pc_o=0x200 and pending_o=0.
- Trap priority:
  - Trap and redirect(0x300) in the same cycle -> pc_o=0x80.
  - Trap latched during a stall, then redirect(0x300) still stalled -> on release, pc_o=0x80.
- RAS (PC_RAS_EN, depth 4):
  - Call at pc 0x10 to 0x400 -> pc_o=0x400 and ras_empty_o=0.
  - Ret -> pc_o=0x14 and ras_empty_o=1.
  - Five nested calls then five rets -> the four newest return addresses come back in LIFO order, then the fifth ret uses redirect_pc_i.
- Without PC_RAS_EN: ret_i with redirect_pc_i=0x500 -> pc_o=0x500, and ras_empty_o stays 1 throughout.

Source files
------------

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program-counter unit for the IF stage.
//
// Holds the fetch PC and advances it by INC each cycle. It takes redirects from
// trap (highest priority) and branch/jump/ret sources. A request that arrives
// while the PC is stalled is latched as a single pending entry and applied on
// the first cycle the PC may update again.
//
// Optional feature macro: PC_RAS_EN
//   defined   -> a circular return-address stack of RAS_DEPTH entries supplies
//                ret targets and records call return addresses.
//   undefined -> no RAS storage; call_i/ret_i are ignored, ras_empty_o = 1.
//
// Parameters:
//   WIDTH      PC width in bits
//   RESET_VEC  PC after reset
//   TRAP_VEC   PC target on trap
//   INC        sequential increment
//   RAS_DEPTH  RAS entries (power of two, >= 2)
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             asynchronous active-high reset
//   pc_write_i        1 = PC may update, 0 = stall
//   trap_i            redirect to TRAP_VEC
//   redirect_valid_i  branch/jump/ret redirect request
//   redirect_pc_i     redirect target (used verbatim)
//   call_i            redirect is a call: push return address
//   ret_i             redirect is a return: pop RAS for target
//   pc_o              current fetch PC (registered)
//   pending_o         a latched redirect awaits application (registered)
//   ras_empty_o       RAS holds no entries (registered)
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'('h80),
    parameter logic [WIDTH-1:0] INC       = WIDTH'(4),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pc_write_i,
    input  logic             trap_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic             call_i,
    input  logic             ret_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             pending_o,
    output logic             ras_empty_o
);

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_TRAP,
        SEL_REDIR
    } sel_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_q, pend_d;
    logic             pend_trap_q, pend_trap_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             pend_call_q, pend_call_d;
    logic             pend_ret_q, pend_ret_d;
    logic             ras_empty_q, ras_empty_d;

    logic [WIDTH-1:0] seq_pc;
    sel_e             sel;
    // Redirect actually applied to the PC this cycle (live or from pending).
    logic             app_en;
    logic [WIDTH-1:0] app_pc;
    logic             app_call;
    logic             app_ret;
    logic [WIDTH-1:0] redir_tgt;

    assign seq_pc = pc_q + INC;

    // Request selection and pending-entry management.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        sel         = SEL_HOLD;
        app_en      = 1'b0;
        app_pc      = redirect_pc_i;
        app_call    = 1'b0;
        app_ret     = 1'b0;
        pend_d      = pend_q;
        pend_trap_d = pend_trap_q;
        pend_pc_d   = pend_pc_q;
        pend_call_d = pend_call_q;
        pend_ret_d  = pend_ret_q;

        if (pc_write_i) begin
            // Any pending entry is either consumed or overridden.
            pend_d = 1'b0;
            if (trap_i) begin
                sel = SEL_TRAP;
            end else if (redirect_valid_i) begin
                sel      = SEL_REDIR;
                app_en   = 1'b1;
                app_pc   = redirect_pc_i;
                app_call = call_i;
                app_ret  = ret_i;
            end else if (pend_q) begin
                if (pend_trap_q) begin
                    sel = SEL_TRAP;
                end else begin
                    sel      = SEL_REDIR;
                    app_en   = 1'b1;
                    app_pc   = pend_pc_q;
                    app_call = pend_call_q;
                    app_ret  = pend_ret_q;
                end
            end else begin
                sel = SEL_SEQ;
            end
        end else begin
            if (trap_i) begin
                pend_d      = 1'b1;
                pend_trap_d = 1'b1;
                pend_call_d = 1'b0;
                pend_ret_d  = 1'b0;
            end else if (redirect_valid_i && !(pend_q && pend_trap_q)) begin
                // Newest redirect wins; a pending trap is never displaced.
                pend_d      = 1'b1;
                pend_trap_d = 1'b0;
                pend_pc_d   = redirect_pc_i;
                pend_call_d = call_i;
                pend_ret_d  = ret_i;
            end
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    sp_q, sp_d;      // next free slot; top of stack is sp_q-1
    logic [PW:0]      cnt_q, cnt_d;    // valid entries, saturates at RAS_DEPTH
    logic             ras_we;
    logic [PW-1:0]    ras_waddr;
    logic [PW-1:0]    top_idx;
    logic             has_top;

    assign top_idx = sp_q - 1'b1;
    assign has_top = (cnt_q != '0);

    always_comb begin
        redir_tgt = app_pc;
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = sp_q;

        if (app_en) begin
            if (app_ret && has_top) begin
                redir_tgt = ras_q[top_idx];
            end
            if (app_call && app_ret && has_top) begin
                // Pop then push collapses to overwriting the top in place.
                ras_we    = 1'b1;
                ras_waddr = top_idx;
            end else if (app_call) begin
                // When full, the write lands on the oldest entry (circular).
                ras_we = 1'b1;
                sp_d   = sp_q + 1'b1;
                if (cnt_q != (PW+1)'(RAS_DEPTH)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (app_ret && has_top) begin
                sp_d  = top_idx;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign ras_empty_d = (cnt_d == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the stack storage has no reset; the entry count guards every read,
    // so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (ras_we) begin
            ras_q[ras_waddr] <= seq_pc;
        end
    end
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_ras_flags;

    assign unused_ras_flags = app_call ^ app_ret;
    assign redir_tgt        = app_pc;
    assign ras_empty_d      = 1'b1;
`endif

    always_comb begin
        unique case (sel)
            SEL_SEQ:   pc_d = seq_pc;
            SEL_TRAP:  pc_d = TRAP_VEC;
            SEL_REDIR: pc_d = redir_tgt;
            default:   pc_d = pc_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q        <= RESET_VEC;
            pend_q      <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_pc_q   <= '0;
            pend_call_q <= 1'b0;
            pend_ret_q  <= 1'b0;
            ras_empty_q <= 1'b1;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_trap_q <= pend_trap_d;
            pend_pc_q   <= pend_pc_d;
            pend_call_q <= pend_call_d;
            pend_ret_q  <= pend_ret_d;
            ras_empty_q <= ras_empty_d;
        end
    end

    assign pc_o        = pc_q;
    assign pending_o   = pend_q;
    assign ras_empty_o = ras_empty_q;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit.
//
// A 32-bit instance is driven by directed steps followed by randomized steps
// and compared against a behavioural model (RAS kept as a queue). An 8-bit
// instance exercises the modulo-2^WIDTH wrap of the sequential increment.
// Expectations for the RAS follow whether PC_RAS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    localparam logic [31:0] TRAP_V = 32'h80;
    localparam logic [31:0] INC_V  = 32'd4;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pw, tr, rv, ca, re;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        pend, rempty;

    logic        rv8;
    logic [7:0]  rpc8;
    logic [7:0]  pc8;
    logic        pend8, rempty8;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state.
    logic [31:0] m_pc;
    bit          m_pend, m_ptrap, m_pcall, m_pret;
    logic [31:0] m_ppc;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h80), .INC(32'd4), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pc_write_i(pw), .trap_i(tr),
        .redirect_valid_i(rv), .redirect_pc_i(rpc), .call_i(ca), .ret_i(re),
        .pc_o(pc), .pending_o(pend), .ras_empty_o(rempty)
    );

    pc_unit #(
        .WIDTH(8), .RESET_VEC(8'h0), .TRAP_VEC(8'h80), .INC(8'd4), .RAS_DEPTH(DEPTH)
    ) dut8 (
        .clk_i(clk), .rst_i(rst), .pc_write_i(1'b1), .trap_i(1'b0),
        .redirect_valid_i(rv8), .redirect_pc_i(rpc8), .call_i(1'b0), .ret_i(1'b0),
        .pc_o(pc8), .pending_o(pend8), .ras_empty_o(rempty8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_empty();
`ifdef PC_RAS_EN
        return (m_ras.size() == 0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_pend  = 1'b0;
        m_ptrap = 1'b0;
        m_pcall = 1'b0;
        m_pret  = 1'b0;
        m_ppc   = 32'h0;
        m_ras.delete();
    endtask

    // Applies a redirect: ret takes the stack top if any, call pushes pc+INC.
    task automatic model_apply(input logic [31:0] tgt, input bit c, input bit r);
        logic [31:0] nxt;
        nxt = tgt;
`ifdef PC_RAS_EN
        if (r && m_ras.size() > 0) nxt = m_ras.pop_back();
        if (c) begin
            m_ras.push_back(m_pc + INC_V);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
`endif
        m_pc = nxt;
    endtask

    task automatic model_step(input bit p, input bit t, input bit v,
                              input logic [31:0] a, input bit c, input bit r);
        if (p) begin
            if (t) m_pc = TRAP_V;
            else if (v) model_apply(a, c, r);
            else if (m_pend) begin
                if (m_ptrap) m_pc = TRAP_V;
                else model_apply(m_ppc, m_pcall, m_pret);
            end else m_pc = m_pc + INC_V;
            m_pend = 1'b0;
        end else if (t) begin
            m_pend  = 1'b1;
            m_ptrap = 1'b1;
        end else if (v && !(m_pend && m_ptrap)) begin
            m_pend  = 1'b1;
            m_ptrap = 1'b0;
            m_ppc   = a;
            m_pcall = c;
            m_pret  = r;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pending"}, {31'b0, pend}, {31'b0, m_pend});
        check({tag, ".ras_empty"}, {31'b0, rempty}, {31'b0, exp_empty()});
    endtask

    // One clock of stimulus: drive, advance the model, sample #1 after the edge.
    task automatic step(input string tag, input bit p, input bit t, input bit v,
                        input logic [31:0] a, input bit c, input bit r);
        pw = p; tr = t; rv = v; rpc = a; ca = c; re = r;
        model_step(p, t, v, a, c, r);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Asserts reset between clock edges and checks the immediate effect.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".pc"}, pc, 32'h0);
        check({tag, ".pending"}, {31'b0, pend}, 32'h0);
        check({tag, ".ras_empty"}, {31'b0, rempty}, 32'h1);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_ret [5];

        rst = 1'b1;
        pw = 1'b1; tr = 1'b0; rv = 1'b0; rpc = 32'h0; ca = 1'b0; re = 1'b0;
        rv8 = 1'b0; rpc8 = 8'h0;
        model_reset();

        // Reset holds the PC at RESET_VEC even across clock edges.
        #1;
        check("reset.pc", pc, 32'h0);
        check("reset.pending", {31'b0, pend}, 32'h0);
        check("reset.ras_empty", {31'b0, rempty}, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_edges.pc", pc, 32'h0);
        rst = 1'b0;

        // Free run.
        idle("run1"); check("run1.lit", pc, 32'd4);
        idle("run2"); check("run2.lit", pc, 32'd8);
        idle("run3"); check("run3.lit", pc, 32'd12);

        // Reset mid-stall discards the pending redirect.
        step("stall_pre_rst", 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        async_reset("async_rst");

        // 8-bit wrap: 0xFC + 4 = 0x00.
        rv8 = 1'b1; rpc8 = 8'hFC;
        idle("w0");
        check("wrap_load", {24'b0, pc8}, 32'hFC);
        rv8 = 1'b0;
        idle("w1");
        check("wrap_zero", {24'b0, pc8}, 32'h00);
        idle("w2");
        check("wrap_next", {24'b0, pc8}, 32'h04);

        // Stalled redirects: newest wins on release.
        step("stall_r1", 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        check("stall_r1.pend", {31'b0, pend}, 32'h1);
        step("stall_r2", 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        idle("stall_rel");
        check("stall_rel.lit", pc, 32'h200);
        check("stall_rel.pend", {31'b0, pend}, 32'h0);

        // Trap priority, live and pending.
        step("trap_live", 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
        check("trap_live.lit", pc, 32'h80);
        step("trap_st", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step("trap_st_r", 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
        idle("trap_rel");
        check("trap_rel.lit", pc, 32'h80);

        // Call / ret.
        step("to_10", 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        step("call", 1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0);
        check("call.lit", pc, 32'h400);
`ifdef PC_RAS_EN
        check("call.empty", {31'b0, rempty}, 32'h0);
`else
        check("call.empty", {31'b0, rempty}, 32'h1);
`endif
        step("ret", 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 1'b1);
`ifdef PC_RAS_EN
        check("ret.lit", pc, 32'h14);
`else
        check("ret.lit", pc, 32'h500);
`endif
        check("ret.empty", {31'b0, rempty}, 32'h1);

        // Five nested calls then five rets: depth 4 keeps the four newest.
`ifdef PC_RAS_EN
        exp_ret[0] = 32'h2304; exp_ret[1] = 32'h2204; exp_ret[2] = 32'h2104;
        exp_ret[3] = 32'h2004; exp_ret[4] = 32'hABC0;
`else
        for (int i = 0; i < 5; i++) exp_ret[i] = 32'hABC0;
`endif
        step("to_1000", 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step($sformatf("ncall%0d", i), 1'b1, 1'b0, 1'b1, 32'h2000 + 32'(i) * 32'h100, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("nret%0d", i), 1'b1, 1'b0, 1'b1, 32'hABC0, 1'b0, 1'b1);
            check($sformatf("nret%0d.lit", i), pc, exp_ret[i]);
        end

        // Randomized traffic, including stalls, call+ret and occasional reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset($sformatf("rrst%0d", i));
            end else begin
                step($sformatf("rand%0d", i),
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
